imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Single-port arbiter for the unified instruction/data `memory` block.
- Shares it between two requesters: the fetch stage (read-only) and the data/LSU path (read/write).
- Sits between the requesters and `memory`; drives its addr/data/read_en/write_en pins and routes returned read data to the owning requester.
- Data side has priority; a bounded-streak counter prevents fetch starvation.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MAX_DM_STREAK, 4, max consecutive data grants while fetch is waiting (legal range 1..15)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- if_req_i  input  1  fetch read request
- if_addr_i  input  AWIDTH  fetch address
- if_flush_i  input  1  discard outstanding fetch response (redirect)
- if_gnt_o  output  1  fetch request accepted this cycle
- if_rvalid_o  output  1  fetch read data valid
- if_rdata_o  output  DWIDTH  fetch read data
- dm_req_i  input  1  data request
- dm_we_i  input  1  1 = write, 0 = read
- dm_addr_i  input  AWIDTH  data address
- dm_wdata_i  input  DWIDTH  write data
- dm_gnt_o  output  1  data request accepted this cycle
- dm_rvalid_o  output  1  data read data valid
- dm_rdata_o  output  DWIDTH  data read data
- mem_addr_o  output  AWIDTH  to memory addr_i
- mem_wdata_o  output  DWIDTH  to memory data_i
- mem_read_en_o  output  1  to memory read_en_i
- mem_write_en_o  output  1  to memory write_en_i
- mem_rdata_i  input  DWIDTH  from memory data_o

Behaviour:
- One clock `clk`; reset `rst` is synchronous, active-high.
- Memory contract: read data appears on mem_rdata_i exactly 1 cycle after the cycle with mem_read_en_o=1. Writes commit at the clock edge of the grant cycle.
- Grant and memory drive are combinational, same cycle as the request. At most one grant per cycle; a requester holds req/addr/wdata stable until it sees gnt.
- Arbitration per cycle:
  - Only one requester active: that one wins.
  - Both active, streak < MAX_DM_STREAK: data wins.
  - Both active, streak == MAX_DM_STREAK: fetch wins.
- Streak counter (4 bits):
  - +1 on each data grant while if_req_i=1.
  - Cleared on any fetch grant, or any cycle with if_req_i=0.
  - Saturates at MAX_DM_STREAK.
- Memory drive when granted:
  - Fetch grant: mem_addr_o=if_addr_i, mem_read_en_o=1.
  - Data grant: mem_addr_o=dm_addr_i, mem_wdata_o=dm_wdata_i, mem_read_en_o=!dm_we_i, mem_write_en_o=dm_we_i.
  - No grant: read_en=0, write_en=0, addr=0, wdata=0.
- Response tracking: registered owner tag {NONE, IF, DM}, captured on each read grant; set to NONE on a write or idle cycle. Back-to-back reads are fully pipelined, one per cycle.
- Response: the cycle after a read grant, the owner's rvalid_o=1 with rdata_o=mem_rdata_i (combinational pass-through). Non-owner rvalid=0; every rdata_o is 0 when its rvalid is 0.
- Writes produce no rvalid.
- Flush:
  - if_flush_i=1 while tag==IF: if_rvalid_o forced 0 that cycle (response dropped).
  - if_flush_i=1 in the same cycle as a fetch grant: that grant is still issued, and its response next cycle is dropped (flush-pending flop).
  - A flush never affects the DM path.
- Reset values: tag=NONE, streak=0, flush-pending=0; all *_gnt_o, *_rvalid_o, mem_*_en_o = 0.
- Reset asserted mid-read: the response in the following cycle is suppressed (tag cleared). Grants are blocked while rst=1.
- No combinational path from *_rvalid_o to *_gnt_o.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x0100_0000 for 3 cycles -> if_gnt_o=1 each cycle; mem_read_en_o=1; if_rvalid_o=1 on cycles 2-4 with mem_rdata_i values in order.
- Contention: dm_req_i read and if_req_i both held high for 10 cycles, MAX_DM_STREAK=4 -> grant pattern DDDDF DDDDF; each dm_rvalid/if_rvalid appears 1 cycle after its grant.
- Data write: dm_we_i=1, dm_addr_i=0x0100_0010, dm_wdata_i=0xDEADBEEF -> mem_write_en_o=1 with matching addr/wdata, mem_read_en_o=0, no rvalid next cycle. A following fetch read of the same address returns 0xDEADBEEF.
- Flush: fetch granted at cycle N, if_flush_i=1 at N+1 -> if_rvalid_o=0 at N+1. Same-cycle flush at grant -> response also dropped. DM read at N+1 is unaffected.
- Reset mid-op: fetch granted at cycle N, rst=1 at N+1 -> no rvalid at N+1 or N+2; all outputs 0 while rst=1; streak restarts at 0 afterwards.
- Idle: no requests -> mem_read_en_o=0, mem_write_en_o=0, mem_addr_o=0, streak held at 0.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Single-port arbiter that shares the unified instruction/data memory
//   between the fetch stage (read-only) and the data/LSU path (read/write).
//   Data side normally wins. A bounded streak counter lets fetch in after
//   MAX_DM_STREAK back-to-back data grants made while fetch was waiting.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req_i/if_addr_i            fetch read request
//   if_flush_i                    drop the outstanding fetch response
//   if_gnt_o                      fetch accepted this cycle
//   if_rvalid_o/if_rdata_o        fetch response (one cycle after grant)
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i   data request
//   dm_gnt_o                      data accepted this cycle
//   dm_rvalid_o/dm_rdata_o        data read response (one cycle after grant)
//   mem_addr_o/mem_wdata_o/mem_read_en_o/mem_write_en_o   memory drive
//   mem_rdata_i                   memory read data (one cycle latency)
module imem_dmem_arbiter #(
  parameter int AWIDTH        = 32,
  parameter int DWIDTH        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AWIDTH-1:0] dm_addr_i,
  input  logic [DWIDTH-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DWIDTH-1:0] dm_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  // Owner of the read that is in flight in memory this cycle.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IF,
    TAG_DM
  } tag_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  tag_t       tag_q, tag_d;
  logic [3:0] streak_q, streak_d;
  logic       flush_pend_q, flush_pend_d;
  logic       if_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q        <= TAG_NONE;
      streak_q     <= 4'd0;
      flush_pend_q <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      streak_q     <= streak_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    // Fetch wins when it is alone, or when data has used up its streak.
    if_wins        = if_req_i && (!dm_req_i || (streak_q >= STREAK_MAX));
    if_gnt_o       = !rst && if_wins;
    dm_gnt_o       = !rst && dm_req_i && !if_wins;

    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    tag_d          = TAG_NONE;

    if (if_gnt_o) begin
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
      tag_d         = TAG_IF;
    end else if (dm_gnt_o) begin
      mem_addr_o     = dm_addr_i;
      mem_wdata_o    = dm_wdata_i;
      mem_read_en_o  = !dm_we_i;
      mem_write_en_o = dm_we_i;
      tag_d          = dm_we_i ? TAG_NONE : TAG_DM;
    end

    // A flush raised alongside a fetch grant must kill next cycle's data.
    flush_pend_d = if_gnt_o && if_flush_i;

    // Streak only counts data grants that actually made fetch wait.
    if (!if_req_i || if_gnt_o)
      streak_d = 4'd0;
    else if (dm_gnt_o && (streak_q < STREAK_MAX))
      streak_d = streak_q + 4'd1;
    else
      streak_d = streak_q;

    // Responses are gated by rst so a read issued just before reset is lost.
    if_rvalid_o = !rst && (tag_q == TAG_IF) && !if_flush_i && !flush_pend_q;
    dm_rvalid_o = !rst && (tag_q == TAG_DM);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  end

endmodule
